// File: rtl/pc_fetch_gen.sv
// Fetch-address generator: owns the PC, selects trap / redirect / predicted / sequential next address
// and offers it to imem over valid/ready. Define PC_RAS_EN to add a circular return-address stack.
module pc_fetch_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             trap,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             pd_call,
    input  logic             pd_ret,
    input  logic             pc_ready,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc,
    output logic             misalign,
    output logic             halted
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             in_run;
    logic             accept;
    logic             outstanding;
    logic             take_trap;
    logic             take_redir;
    logic             redir_misal;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] pred_pc;
    logic [WIDTH-1:0] pc_nxt;
    logic             misalign_nxt;

    assign in_run      = (state == S_RUN);
    assign accept      = pc_valid && pc_ready;
    assign outstanding = pc_valid && !pc_ready;
    assign seq_pc      = pc + WIDTH'(INC);

    // Traps act in RUN and HALTED; redirects only while running. Trap outranks redirect.
    assign take_trap   = trap && (state != S_BOOT);
    assign take_redir  = redirect && in_run && !trap;
    assign redir_misal = take_redir && (redirect_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this combinational block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // A trap or redirect flushes the pending request, so it cannot block the halt.
                if (halt_req && (!outstanding || trap || redirect)) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (trap || resume) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_valid = 1'b0;
        halted   = 1'b0;
        case (state)
            S_RUN:    pc_valid = !stall;
            S_HALTED: halted   = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC selection and PC register
    // ------------------------------------------------------------------
    always_comb begin
        pc_nxt       = pc;
        misalign_nxt = 1'b0;
        if (take_trap) begin
            pc_nxt = TRAP_VECTOR;
        end else if (take_redir) begin
            if (redir_misal) begin
                pc_nxt       = TRAP_VECTOR;
                misalign_nxt = 1'b1;
            end else begin
                pc_nxt = redirect_pc;
            end
        end else if (accept) begin
            pc_nxt = pred_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            misalign <= misalign_nxt;
        end
    end

`ifdef PC_RAS_EN
    // ------------------------------------------------------------------
    // Return-address stack: circular buffer, newest entry at ras_top.
    // ------------------------------------------------------------------
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic [PTR_W-1:0] push_idx;
    logic             ras_upd;
    logic             ras_nonempty;
    logic             ras_pop;
    logic             ras_push;

    // The instruction accepted alongside a redirect is wrong-path, so it never touches the stack.
    assign ras_upd      = accept && !trap && !redirect;
    assign ras_nonempty = (ras_cnt != '0);
    assign ras_pop      = ras_upd && pd_ret && ras_nonempty;
    assign ras_push     = ras_upd && pd_call;
    assign pred_pc      = ras_pop ? ras_mem[ras_top] : seq_pc;
    assign push_idx     = ras_pop ? ras_top : ras_top + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (take_trap) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else begin
            case ({ras_push, ras_pop})
                2'b10: begin
                    ras_top <= ras_top + PTR_W'(1);
                    if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
                        ras_cnt <= ras_cnt + CNT_W'(1);
                    end
                end
                2'b01: begin
                    ras_top <= ras_top - PTR_W'(1);
                    ras_cnt <= ras_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: the stack array is deliberately not reset; ras_cnt gates every read of it.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[push_idx] <= seq_pc;
        end
    end
`else
    logic unused_ras_inputs;

    assign pred_pc           = seq_pc;
    assign unused_ras_inputs = ^{pd_call, pd_ret, 32'(RAS_DEPTH)};
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Scoreboard bench for pc_fetch_gen: a queue-based reference model predicts every cycle's outputs,
// a monitor compares them; directed spot checks plus randomized traffic. Honours PC_RAS_EN.
module tb_pc_fetch_gen;

    localparam logic [31:0] RESET_V   = 32'h0000_0000;
    localparam logic [31:0] TRAP_V    = 32'h0000_0100;
    localparam int          INC       = 4;
    localparam int          RAS_DEPTH = 4;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        trap;
        logic        halt_req;
        logic        resume;
        logic        pd_call;
        logic        pd_ret;
        logic        pc_ready;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        mis;
        logic        halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        pd_call = 1'b0;
    logic        pd_ret = 1'b0;
    logic        pc_ready = 1'b0;
    logic        pc_valid;
    logic [31:0] pc;
    logic        misalign;
    logic        halted;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model state: plain flags, a PC and a bounded queue for the return stack.
    logic        m_boot;
    logic        m_halt;
    logic        m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    pc_fetch_gen #(
        .WIDTH(32), .RESET_VECTOR(RESET_V), .TRAP_VECTOR(TRAP_V), .INC(INC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .trap(trap), .halt_req(halt_req), .resume(resume), .pd_call(pd_call), .pd_ret(pd_ret),
        .pc_ready(pc_ready), .pc_valid(pc_valid), .pc(pc), .misalign(misalign), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic stim_t st(input logic ready = 1'b1, input logic stall_i = 1'b0,
                                 input logic redir = 1'b0, input logic [31:0] tgt = 32'h0,
                                 input logic trap_i = 1'b0, input logic halt = 1'b0,
                                 input logic res = 1'b0, input logic call = 1'b0,
                                 input logic ret = 1'b0, input logic rst_i = 1'b0);
        stim_t s;
        s.rst = rst_i;   s.stall = stall_i;  s.redirect = redirect ? 1'b0 : redir;
        s.redirect = redir; s.redirect_pc = tgt; s.trap = trap_i; s.halt_req = halt;
        s.resume = res;  s.pd_call = call;   s.pd_ret = ret;   s.pc_ready = ready;
        return s;
    endfunction

    task automatic model_reset();
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_mis  = 1'b0;
        m_pc   = RESET_V;
        m_ras.delete();
    endtask

    task automatic model_step(input stim_t s, output exp_t e);
        logic        run, valid, acc, go_halt, nmis;
        logic [31:0] pred;
        run     = !m_boot && !m_halt;
        valid   = run && !s.stall;
        acc     = valid && s.pc_ready;
        e       = '{valid: valid, pc: m_pc, mis: m_mis, halted: m_halt};
        nmis    = 1'b0;
        go_halt = 1'b0;
        pred    = m_pc + 32'(INC);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (s.trap) begin
                m_pc = TRAP_V;
                m_ras.delete();
                m_halt = 1'b0;
            end else if (s.resume) begin
                m_halt = 1'b0;
            end
        end else begin
            go_halt = s.halt_req && (!(valid && !s.pc_ready) || s.trap || s.redirect);
            if (s.trap) begin
                m_pc = TRAP_V;
                m_ras.delete();
            end else if (s.redirect) begin
                if (s.redirect_pc[1:0] != 2'b00) begin
                    m_pc = TRAP_V;
                    nmis = 1'b1;
                end else begin
                    m_pc = s.redirect_pc;
                end
            end else if (acc) begin
`ifdef PC_RAS_EN
                if (s.pd_ret && m_ras.size() > 0) pred = m_ras.pop_back();
                if (s.pd_call) begin
                    m_ras.push_back(m_pc + 32'(INC));
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end
`endif
                m_pc = pred;
            end
            m_halt = go_halt;
        end
        m_mis = nmis;
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the outputs the model predicts.
    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; stall = s.stall; redirect = s.redirect; redirect_pc = s.redirect_pc;
        trap = s.trap; halt_req = s.halt_req; resume = s.resume;
        pd_call = s.pd_call; pd_ret = s.pd_ret; pc_ready = s.pc_ready;
        if (s.rst) begin
            model_reset();
            e = '{valid: 1'b0, pc: RESET_V, mis: 1'b0, halted: 1'b0};
        end else begin
            model_step(s, e);
        end
        exp_q.push_back(e);
    endtask

    // Directed spot check against literal values, taken mid-cycle after the inputs settle.
    task automatic peek(input string name, input logic v, input logic [31:0] p,
                        input logic m, input logic h);
        #2;
        check(name, {60'h0, pc_valid, misalign, halted}, {60'h0, v, m, h});
        check({name, "_pc"}, {32'h0, pc}, {32'h0, p});
    endtask

    function automatic stim_t rand_stim();
        stim_t       s;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       r = {r[31:2], 2'b00};
            1:       r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
            2:       r = r & 32'h0000_03FC;
            default: ;
        endcase
        s.rst         = ($urandom_range(0, 599) == 0);
        s.pc_ready    = ($urandom_range(0, 3) != 0);
        s.stall       = ($urandom_range(0, 7) == 0);
        s.trap        = ($urandom_range(0, 39) == 0);
        s.redirect    = ($urandom_range(0, 11) == 0);
        s.redirect_pc = r;
        s.halt_req    = ($urandom_range(0, 19) == 0) && !s.trap && !s.redirect;
        s.resume      = ($urandom_range(0, 4) == 0);
        s.pd_call     = ($urandom_range(0, 3) == 0) && !s.trap && !s.redirect;
        s.pd_ret      = ($urandom_range(0, 3) == 0) && !s.trap && !s.redirect;
        return s;
    endfunction

    // Monitor: every settled cycle with a queued prediction is compared against the DUT.
    initial begin
        exp_t got;
        exp_t want;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{valid: pc_valid, pc: pc, mis: misalign, halted: halted};
                check($sformatf("cyc%0d", n), {29'h0, got}, {29'h0, want});
                n++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ret_exp [5];
        stim_t       s;
`ifdef PC_RAS_EN
        ret_exp = '{32'h58, 32'h54, 32'h50, 32'h4C, 32'h50};
`else
        ret_exp = '{32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C};
`endif
        model_reset();
        repeat (3) apply(st(.rst_i(1'b1)));
        peek("reset", 1'b0, 32'h0, 1'b0, 1'b0);

        // Boot, sequential fetch, backpressure, stall
        apply(st());                peek("boot",   1'b0, 32'h0, 1'b0, 1'b0);
        apply(st());                peek("seq0",   1'b1, 32'h0, 1'b0, 1'b0);
        apply(st());                peek("seq4",   1'b1, 32'h4, 1'b0, 1'b0);
        apply(st(.ready(1'b0)));    peek("seq8",   1'b1, 32'h8, 1'b0, 1'b0);
        apply(st(.ready(1'b0)));
        apply(st(.ready(1'b0)));    peek("hold8",  1'b1, 32'h8, 1'b0, 1'b0);
        apply(st(.stall_i(1'b1)));  peek("stall",  1'b0, 32'h8, 1'b0, 1'b0);

        // Redirects, misalignment, trap priority, wrap
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'h200)));
        apply(st(.ready(1'b0)));    peek("redir",  1'b1, 32'h200, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'h202)));
        apply(st());                peek("misal",  1'b1, 32'h100, 1'b1, 1'b0);
        apply(st(.ready(1'b0)));    peek("misal_end", 1'b1, 32'h104, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .trap_i(1'b1), .redir(1'b1), .tgt(32'h300)));
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'hFFFF_FFFC)));
        peek("trap_prio", 1'b1, 32'h100, 1'b0, 1'b0);
        apply(st());                peek("wrap_pre", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'h10)));
        peek("wrap", 1'b1, 32'h0, 1'b0, 1'b0);

        // Halt with accept, resume, halt blocked by outstanding request, trap wake-up
        apply(st(.halt(1'b1)));     peek("halt_pre", 1'b1, 32'h10, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .res(1'b1)));
        peek("halted", 1'b0, 32'h14, 1'b0, 1'b1);
        apply(st(.ready(1'b0), .halt(1'b1)));
        peek("resumed", 1'b1, 32'h14, 1'b0, 1'b0);
        apply(st(.halt(1'b1)));     peek("halt2_pre", 1'b1, 32'h14, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .trap_i(1'b1)));
        peek("halted2", 1'b0, 32'h18, 1'b0, 1'b1);
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'h40)));
        peek("trap_wake", 1'b1, 32'h100, 1'b0, 1'b0);

        // Call / return, then nested calls deeper than the stack
        apply(st(.call(1'b1)));     peek("call", 1'b1, 32'h40, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'h80)));
        peek("after_call", 1'b1, 32'h44, 1'b0, 1'b0);
        apply(st(.ret(1'b1)));      peek("ret_at", 1'b1, 32'h80, 1'b0, 1'b0);
        apply(st(.ready(1'b0), .redir(1'b1), .tgt(32'h44)));
`ifdef PC_RAS_EN
        peek("ret", 1'b1, 32'h44, 1'b0, 1'b0);
`else
        peek("ret", 1'b1, 32'h84, 1'b0, 1'b0);
`endif
        repeat (5) apply(st(.call(1'b1)));
        for (int j = 0; j < 6; j++) begin
            apply(j < 5 ? st(.ret(1'b1)) : st(.ready(1'b0)));
            if (j > 0) peek($sformatf("nest_ret%0d", j), 1'b1, ret_exp[j-1], 1'b0, 1'b0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s = rand_stim();
            apply(s);
        end
        apply(st(.ready(1'b0)));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        check("drain", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
